// File: rtl/clock_bufg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_bufg_pkg
// Description : Shared defaults and the idle-counter width helper for clock_bufg.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_bufg_pkg;

    localparam int unsigned DEFAULT_SYNC_STAGES    = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    // The counter must be able to hold TIMEOUT_CYCLES itself, since that is its saturated value.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_bufg_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_bufg_if
// Description : Clock-gating bundle: clock in, enable in, gated clock and activity flag out.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_bufg_if;

    logic I;
    logic CE;
    logic O;
    logic Active;

    modport master (
        output I,
        output CE,
        input  O,
        input  Active
    );

    modport slave (
        input  I,
        input  CE,
        output O,
        output Active
    );

endinterface
`default_nettype wire

// File: rtl/clock_bufg_sync.sv
`default_nettype none
// ============================================================================
// Module      : clock_bufg_sync
// Description : Reusable STAGES-deep flop chain bringing an asynchronous bit onto InputCLK.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_bufg_sync
    import clock_bufg_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
    input  wire  InputCLK,
    input  wire  nReset,
    input  wire  d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clock_bufg.sv
`default_nettype none
// ============================================================================
// Module      : clock_bufg
// Description : Glitch-free clock gate (latch + AND) with synchronised enable and an
//               optional activity monitor on I, enabled by CLOCK_BUFG_ACTIVITY_MON_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_bufg
    import clock_bufg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  wire  InputCLK,
    input  wire  nReset,
    input  wire  I,
    input  wire  CE,
    output logic O,
    output logic Active
);

    logic en_sync;
    logic gate_latch;

    clock_bufg_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_sync (
        .InputCLK (InputCLK),
        .nReset   (nReset),
        .d        (CE),
        .q        (en_sync)
    );

    // Only open while I is low, so O can never start or end part-way through a high phase.
    always_latch begin
        if (!nReset) begin
            gate_latch <= 1'b0;
        end else if (!I) begin
            gate_latch <= en_sync;
        end
    end

    assign O = I & gate_latch;

`ifdef CLOCK_BUFG_ACTIVITY_MON_EN
    localparam int unsigned      CNT_W   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic             samp1_q;
    logic             samp1_d;
    logic             samp2_q;
    logic             samp2_d;
    logic             edge_det;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] idle_cnt_d;

    always_comb begin
        samp1_d    = I;
        samp2_d    = samp1_q;
        edge_det   = samp1_q ^ samp2_q;
        idle_cnt_d = idle_cnt_q;
        // An edge clears even on the cycle the counter would otherwise saturate.
        if (edge_det) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CNT_MAX) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset) begin
            samp1_q    <= 1'b0;
            samp2_q    <= 1'b0;
            idle_cnt_q <= CNT_MAX;
        end else begin
            samp1_q    <= samp1_d;
            samp2_q    <= samp2_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign Active = (idle_cnt_q < CNT_MAX);
`else
    assign Active = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_bufg.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_bufg
// Description : Directed, table-driven self-checking bench for clock_bufg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_bufg;

    localparam int NV = 85;

`ifdef CLOCK_BUFG_ACTIVITY_MON_EN
    localparam logic RST_ACT = 1'b0;
`else
    localparam logic RST_ACT = 1'b1;
`endif

    typedef struct {
        logic i;
        logic ce;
        logic exp_o;
        logic exp_act;
    } vec_t;

    logic InputCLK = 1'b0;
    logic nReset;
    int   n_tests  = 0;
    int   n_fail   = 0;
    vec_t vecs [NV];

    clock_bufg_if bus ();

    clock_bufg #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .InputCLK (InputCLK),
        .nReset   (nReset),
        .I        (bus.I),
        .CE       (bus.CE),
        .O        (bus.O),
        .Active   (bus.Active)
    );

    always #5 InputCLK = ~InputCLK;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic i_v, input logic ce_v);
        @(posedge InputCLK);
        #1;
        bus.I  = i_v;
        bus.CE = ce_v;
        @(negedge InputCLK);
    endtask

    // Releases reset on row 0, then one row per InputCLK cycle.
    task automatic run_table(input string tag);
        for (int j = 0; j < NV; j++) begin
            @(posedge InputCLK);
            #1;
            if (j == 0) nReset = 1'b1;
            bus.I  = vecs[j].i;
            bus.CE = vecs[j].ce;
            @(negedge InputCLK);
            check($sformatf("%s O[%0d]", tag, j), bus.O, vecs[j].exp_o);
            check($sformatf("%s Active[%0d]", tag, j), bus.Active, vecs[j].exp_act);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // I toggles every 5 cycles starting high; CE drops at 31 (I high), rises at 50 (I high), drops at 75 (I low).
        for (int j = 0; j < NV; j++) begin
            vecs[j].i     = (((j / 5) % 2) == 0);
            vecs[j].ce    = (j < 31) || (j >= 50 && j < 75);
            vecs[j].exp_o = (j >= 10 && j <= 14) || (j >= 20 && j <= 24) ||
                            (j >= 30 && j <= 34) || (j >= 60 && j <= 64) ||
                            (j >= 70 && j <= 74);
`ifdef CLOCK_BUFG_ACTIVITY_MON_EN
            vecs[j].exp_act = (j >= 2);
`else
            vecs[j].exp_act = 1'b1;
`endif
        end

        nReset = 1'b0;
        bus.I  = 1'b0;
        bus.CE = 1'b1;
        #1;
        check("reset O", bus.O, 1'b0);
        check("reset Active", bus.Active, RST_ACT);
        step(1'b1, 1'b1);
        check("reset O with I high", bus.O, 1'b0);
        check("reset Active hold", bus.Active, RST_ACT);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("reset O late", bus.O, 1'b0);

        run_table("first");

        // Open the gate, enter a high pulse, then reset asynchronously in the middle of it.
        repeat (5) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("pulse before reset", bus.O, 1'b1);
        #1;
        nReset = 1'b0;
        #1;
        check("async reset O", bus.O, 1'b0);
        check("async reset Active", bus.Active, RST_ACT);
        step(1'b1, 1'b1);
        check("reset held O", bus.O, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        run_table("rerun");

`ifdef CLOCK_BUFG_ACTIVITY_MON_EN
        // Last change of I was row 80, so the counter clears at edge 82 and saturates at 98.
        for (int k = 85; k < 98; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("idle Active[%0d]", k), bus.Active, 1'b1);
        end
        step(1'b1, 1'b0);
        check("timeout Active", bus.Active, 1'b0);
        step(1'b1, 1'b0);
        check("timeout Active held", bus.Active, 1'b0);
        step(1'b0, 1'b0);
        check("toggle Active +0", bus.Active, 1'b0);
        step(1'b0, 1'b0);
        check("toggle Active +1", bus.Active, 1'b0);
        step(1'b0, 1'b0);
        check("toggle Active +2", bus.Active, 1'b1);
        repeat (13) step(1'b0, 1'b0);
        // This toggle is detected on the very cycle the counter would hit saturation.
        step(1'b1, 1'b0);
        check("sat clear Active +0", bus.Active, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("sat clear Active +%0d", k), bus.Active, 1'b1);
        end
`else
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("tied Active[%0d]", k), bus.Active, 1'b1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_bufg.md
CLOCK_BUFG -- requirements
Module: clock_bufg

Interface
REQ-001 The block SHALL expose the parameter SYNC_STAGES, default 2, as the number of InputCLK flops that synchronise CE (legal range 2..4).
REQ-002 The block SHALL expose the parameter TIMEOUT_CYCLES, default 1024, as the number of InputCLK cycles without an edge on I before Active drops (legal range 4..2^20).
REQ-003 The block SHALL have the port InputCLK  input  1  system clock, rising-edge active; the block has one clock.
REQ-004 The block SHALL have the port nReset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have the port I  input  1  clock to be buffered; it is generated synchronously from InputCLK and its frequency is at most InputCLK/4.
REQ-006 The block SHALL have the port CE  input  1  output enable, asynchronous to I.
REQ-007 The block SHALL have the port O  output  1  buffered clock.
REQ-008 The block SHALL have the port Active  output  1  activity flag for I.

Function
REQ-009 CE SHALL pass through a SYNC_STAGES-deep flop chain on InputCLK; the chain output is en_sync.
REQ-010 A gate latch SHALL be transparent while I=0 and hold its value while I=1; its data input is en_sync.
REQ-011 O SHALL equal I AND the gate latch output, so every high pulse on O is a complete high pulse of I.
REQ-012 Enable latency: if CE rises before InputCLK edge k, en_sync SHALL be 1 after edge k+SYNC_STAGES-1; O SHALL start at the first rising edge of I that follows while I is low.
REQ-013 If en_sync rises while I=1, O SHALL stay 0 until I falls and then rises again.
REQ-014 If en_sync falls while I=1, the current O high pulse SHALL complete, and O SHALL stay 0 from the next falling edge of I.
REQ-015 A CE pulse shorter than one InputCLK period MAY be lost, and that loss is accepted; otherwise CE SHALL be sampled without metastability propagating to O.
REQ-016 The activity monitor SHALL sample I into two InputCLK flops and detect either edge by XOR of the two flops.
REQ-017 An idle counter SHALL clear to 0 on a detected edge and increment otherwise, saturating at TIMEOUT_CYCLES.
REQ-018 The counter width SHALL be clog2(TIMEOUT_CYCLES+1).
REQ-019 Active SHALL be 1 when the idle counter is less than TIMEOUT_CYCLES and 0 otherwise.
REQ-020 When an edge is detected in the same cycle that the counter reaches saturation, the clear SHALL take priority.

Reset
REQ-021 Asserting nReset SHALL immediately clear the sync chain and the gate latch, forcing O=0, even in the middle of a high pulse of I (the only permitted truncation of a pulse).
REQ-022 During reset the idle counter SHALL be TIMEOUT_CYCLES and Active SHALL be 0.
REQ-023 After nReset is released, O SHALL stay 0 for at least SYNC_STAGES InputCLK edges.
REQ-024 After nReset is released, O SHALL then follow REQ-012.

Configuration
REQ-025 The macro CLOCK_BUFG_ACTIVITY_MON_EN SHALL compile the activity monitor (REQ-016 to REQ-020) in when defined.
REQ-026 Without CLOCK_BUFG_ACTIVITY_MON_EN, Active SHALL be tied to 1 and no counter logic SHALL be synthesised; all other behaviour SHALL be unchanged.

Structure
REQ-027 The package clock_bufg_pkg SHALL hold the default SYNC_STAGES, the default TIMEOUT_CYCLES and the counter-width helper function.
REQ-028 The synchroniser SHALL be the sub-module clock_bufg_sync (parameter STAGES, ports InputCLK, nReset, d, q), so that it can be reused.
REQ-029 The gate latch, the AND gate and the monitor SHALL remain inline in clock_bufg.

Verification
REQ-030 Reset then CE=1, I = InputCLK/10 at 50% duty -> O=0 through edge 2 after release, then O identical to I from the first full pulse; Active=1 within 6 cycles of the first I edge.
REQ-031 CE dropped while I=1 -> O high pulse completes its full 5 cycles, then O stays 0; no pulse on O shorter than 5 cycles.
REQ-032 CE raised while I=1 -> O stays 0 until the next rising edge of I.
REQ-033 nReset asserted mid-high-pulse -> O=0 in the same delta time and Active=0; after release, recovery follows REQ-030.
REQ-034 I held at 0 with TIMEOUT_CYCLES=16 -> Active falls exactly 16 cycles after the last detected edge; one toggle of I -> Active=1 two cycles later.
REQ-035 Build without CLOCK_BUFG_ACTIVITY_MON_EN -> Active=1 permanently, including during reset.
